// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM line in clk cycles and flags stuck lines.
// Define PWM_CAPTURE_FILTER_EN to insert a FILTER_LEN-cycle glitch filter ahead of edge detection.
module pwm_capture #(
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 65535,
   parameter int FILTER_LEN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             stuck_high,
   output logic             stuck_low,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

   state_t           state;
   state_t           state_nx;
   logic             sync_a;
   logic             s;
   logic             line;
   logic             line_d;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] hi_lat;
   logic [CNT_W-1:0] hi_lat_nx;
   logic [CNT_W-1:0] high_nx;
   logic [CNT_W-1:0] period_nx;
   logic             valid_nx;
   logic             sh_nx;
   logic             sl_nx;
   logic             tmo_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         s      <= 1'b0;
      end else begin
         sync_a <= pwm_in;
         s      <= sync_a;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN + 1);

   logic [FW-1:0] filt_cnt;
   logic          filt;

   // The filtered line follows s only once s has disagreed with it for FILTER_LEN cycles in a row.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt     <= 1'b0;
         filt_cnt <= '0;
      end else if (s == filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
         filt     <= s;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   assign line = filt;
`else
   assign line = s;
`endif

   assign rise    = line & ~line_d;
   assign fall    = ~line & line_d;
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign tmo_hit = (cnt_inc >= TMO);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         line_d     <= 1'b0;
         cnt        <= '0;
         hi_lat     <= '0;
         high_cnt   <= '0;
         period_cnt <= '0;
         meas_valid <= 1'b0;
         stuck_high <= 1'b0;
         stuck_low  <= 1'b0;
      end else begin
         state      <= state_nx;
         line_d     <= line;
         cnt        <= cnt_nx;
         hi_lat     <= hi_lat_nx;
         high_cnt   <= high_nx;
         period_cnt <= period_nx;
         meas_valid <= valid_nx;
         stuck_high <= sh_nx;
         stuck_low  <= sl_nx;
      end
   end

   // An edge always wins over a timeout landing in the same cycle.
   always_comb begin
      state_nx = state;
      if (!en) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    state_nx = ARM;
            ARM:     if (rise) state_nx = HIGH;
            HIGH: begin
               if (fall)         state_nx = LOW;
               else if (tmo_hit) state_nx = ARM;
            end
            LOW: begin
               if (rise)         state_nx = HIGH;
               else if (tmo_hit) state_nx = ARM;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_nx    = cnt;
      hi_lat_nx = hi_lat;
      high_nx   = high_cnt;
      period_nx = period_cnt;
      valid_nx  = 1'b0;
      sh_nx     = stuck_high;
      sl_nx     = stuck_low;
      if (!en) begin
         cnt_nx = '0;
         sh_nx  = 1'b0;
         sl_nx  = 1'b0;
      end else begin
         case (state)
            IDLE: cnt_nx = '0;
            ARM: begin
               // Once parked at TIMEOUT the counter holds, so the flags are only set on arrival.
               if (rise) begin
                  cnt_nx = CNT_W'(1);
               end else if (cnt < TMO) begin
                  cnt_nx = cnt_inc;
                  if (tmo_hit) begin
                     sh_nx = line;
                     sl_nx = ~line;
                  end
               end
            end
            HIGH: begin
               if (fall) begin
                  hi_lat_nx = cnt;
                  cnt_nx    = cnt_inc;
               end else if (tmo_hit) begin
                  cnt_nx = TMO;
                  sh_nx  = 1'b1;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
            LOW: begin
               if (rise) begin
                  period_nx = cnt;
                  high_nx   = hi_lat;
                  valid_nx  = 1'b1;
                  sh_nx     = 1'b0;
                  sl_nx     = 1'b0;
                  cnt_nx    = CNT_W'(1);
               end else if (tmo_hit) begin
                  cnt_nx = TMO;
                  sl_nx  = 1'b1;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
            default: cnt_nx = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table vectors and random PWM periods scored against a period-level model,
// plus hand-written reset, stuck, enable, glitch and mid-run reset sequences.
`timescale 1ns/1ps
module tb_pwm_capture;

   localparam int CNT_W      = 16;
   localparam int TIMEOUT    = 50;
   localparam int FILTER_LEN = 3;
`ifdef PWM_CAPTURE_FILTER_EN
   localparam int FD   = FILTER_LEN;
   localparam int MINW = FILTER_LEN;
`else
   localparam int FD   = 0;
   localparam int MINW = 1;
`endif
   localparam int LAT = 2 + FD;

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b0;
   logic             en     = 1'b0;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic             meas_valid;
   logic             stuck_high;
   logic             stuck_low;
   logic             busy;

   pwm_capture #(
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT),
      .FILTER_LEN(FILTER_LEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .pwm_in    (pwm_in),
      .high_cnt  (high_cnt),
      .period_cnt(period_cnt),
      .meas_valid(meas_valid),
      .stuck_high(stuck_high),
      .stuck_low (stuck_low),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hi;
      int lo;
      int exp_high;
      int exp_period;
   } vec_t;

   typedef struct {
      int high;
      int period;
      int cycle;
   } rep_t;

   rep_t exp_q[$];
   rep_t mon_e;
   int   tests      = 0;
   int   fails      = 0;
   int   cyc        = 0;
   logic prev_valid = 1'b0;
   bit   pend_valid = 1'b0;
   int   pend_h     = 0;
   int   pend_p     = 0;
   int   last_rise  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Every reported period must be one the model predicted, at the predicted cycle.
   always @(negedge clk) begin
      if (meas_valid === 1'b1) begin
         checkOutput("valid_single_cycle", prev_valid, 0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_valid: got high %0d period %0d, expected no report (cycle %0d)",
                     high_cnt, period_cnt, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("report_high_cnt", high_cnt, mon_e.high);
            checkOutput("report_period_cnt", period_cnt, mon_e.period);
            checkOutput("report_cycle", cyc, mon_e.cycle);
         end
      end
      prev_valid <= meas_valid;
   end

   task automatic step(input logic v);
      pwm_in = v;
      @(posedge clk);
      #1;
   endtask

   // A rise that follows a complete period reports that period LAT cycles after it is sampled.
   task automatic modelRise();
      if (pend_valid) exp_q.push_back('{pend_h, pend_p, cyc + 1 + LAT});
      last_rise  = cyc + 1;
      pend_valid = 1'b0;
   endtask

   task automatic applyStimulus(input int hi, input int lo, input int eh, input int ep);
      modelRise();
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
      pend_valid = 1'b1;
      pend_h     = eh;
      pend_p     = ep;
   endtask

   initial begin
      vec_t vecs[$];
      int   h;
      int   l;

      vecs.push_back('{3, 7, 3, 10});
      vecs.push_back('{3, 7, 3, 10});
      vecs.push_back('{7, 3, 7, 10});
      vecs.push_back('{7, 3, 7, 10});
      vecs.push_back('{4, 4, 4, 8});
      vecs.push_back('{20, 29, 20, 49});
      vecs.push_back('{3, 3, 3, 6});
      vecs.push_back('{10, 5, 10, 15});
      vecs.push_back('{5, 44, 5, 49});

      rst_n = 1'b0;
      en    = 1'b0;
      step(1'b1);
      step(1'b0);
      step(1'b1);
      checkOutput("reset_high_cnt", high_cnt, 0);
      checkOutput("reset_period_cnt", period_cnt, 0);
      checkOutput("reset_meas_valid", meas_valid, 0);
      checkOutput("reset_stuck_high", stuck_high, 0);
      checkOutput("reset_stuck_low", stuck_low, 0);
      checkOutput("reset_busy", busy, 0);

      rst_n = 1'b1;
      en    = 1'b1;
      step(1'b0);
      checkOutput("busy_after_enable", busy, 1);
      repeat (4) step(1'b0);

      applyStimulus(3, 7, 3, 10);
      foreach (vecs[i]) applyStimulus(vecs[i].hi, vecs[i].lo, vecs[i].exp_high, vecs[i].exp_period);

      for (int i = 0; i < 25; i++) begin
         h = $urandom_range(20, MINW);
         l = $urandom_range(20, MINW);
         applyStimulus(h, l, h, h + l);
      end

      // Stuck high: flag appears exactly when the count since the rise reaches TIMEOUT.
      modelRise();
      while (cyc < last_rise + TIMEOUT + FD) step(1'b1);
      checkOutput("stuck_high_before_timeout", stuck_high, 0);
      step(1'b1);
      checkOutput("stuck_high_at_timeout", stuck_high, 1);
      checkOutput("stuck_low_during_high", stuck_low, 0);
      checkOutput("busy_while_stuck", busy, 1);
      while (cyc < last_rise + 80) step(1'b1);
      checkOutput("stuck_high_held", stuck_high, 1);
      repeat (10) step(1'b0);
      applyStimulus(3, 7, 3, 10);
      checkOutput("stuck_high_sticky", stuck_high, 1);
      applyStimulus(3, 7, 3, 10);
      checkOutput("stuck_high_cleared", stuck_high, 0);

      while (cyc < last_rise + TIMEOUT + FD) step(1'b0);
      checkOutput("stuck_low_before_timeout", stuck_low, 0);
      step(1'b0);
      checkOutput("stuck_low_at_timeout", stuck_low, 1);
      checkOutput("stuck_high_during_low", stuck_high, 0);
      pend_valid = 1'b0;

      en = 1'b0;
      step(1'b0);
      checkOutput("en_off_clears_stuck_low", stuck_low, 0);
      checkOutput("en_off_busy", busy, 0);
      checkOutput("en_off_hold_high", high_cnt, 3);
      checkOutput("en_off_hold_period", period_cnt, 10);
      en = 1'b1;
      repeat (5) step(1'b0);

      // Enable dropped in the middle of a high phase, then re-enabled.
      applyStimulus(3, 7, 3, 10);
      applyStimulus(6, 4, 6, 10);
      modelRise();
      repeat (8) step(1'b1);
      en = 1'b0;
      repeat (4) step(1'b1);
      checkOutput("en_drop_busy", busy, 0);
      checkOutput("en_drop_hold_high", high_cnt, 6);
      checkOutput("en_drop_hold_period", period_cnt, 10);
      repeat (5) step(1'b0);
      en = 1'b1;
      repeat (5) step(1'b0);
      checkOutput("re_enable_busy", busy, 1);
      applyStimulus(5, 5, 5, 10);
      applyStimulus(4, 4, 4, 8);

      // One-cycle glitch inside the low phase.
      modelRise();
      repeat (3) step(1'b1);
      repeat (3) step(1'b0);
`ifdef PWM_CAPTURE_FILTER_EN
      step(1'b1);
      repeat (3) step(1'b0);
      pend_valid = 1'b1;
      pend_h     = 3;
      pend_p     = 10;
`else
      exp_q.push_back('{3, 6, cyc + 1 + LAT});
      step(1'b1);
      repeat (3) step(1'b0);
      pend_valid = 1'b1;
      pend_h     = 1;
      pend_p     = 4;
`endif
      applyStimulus(3, 7, 3, 10);

      modelRise();
      repeat (8) step(1'b1);
      rst_n = 1'b0;
      step(1'b1);
      pend_valid = 1'b0;
      checkOutput("midrun_reset_high_cnt", high_cnt, 0);
      checkOutput("midrun_reset_period_cnt", period_cnt, 0);
      checkOutput("midrun_reset_busy", busy, 0);
      checkOutput("midrun_reset_valid", meas_valid, 0);
      rst_n = 1'b1;
      repeat (6) step(1'b0);

      checkOutput("all_reports_seen", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Downstream consumer of the PWM generator. Samples one PWM line, measures high time and period in clk cycles, and reports each completed period with a one-cycle valid strobe.
- Flags stuck-high and stuck-low lines after a programmable timeout.
- Used for closed-loop duty checking and for self-test of PWM outputs.

Parameters:
- CNT_W, 16, width of the cycle counters and measurement outputs.
- TIMEOUT, 65535, cycles without an expected edge before a stuck flag is raised; must be ≤ 2^CNT_W−1.
- FILTER_LEN, 3, stability length in cycles for the optional glitch filter; unused when the filter is compiled out.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- en  input  1  capture enable.
- pwm_in  input  1  PWM line under measurement; asynchronous to clk.
- high_cnt  output  CNT_W  high-phase length of the last complete period, in cycles.
- period_cnt  output  CNT_W  rising-to-rising length of the last complete period, in cycles.
- meas_valid  output  1  one-cycle pulse when high_cnt/period_cnt update.
- stuck_high  output  1  line held high ≥ TIMEOUT cycles.
- stuck_low  output  1  line held low ≥ TIMEOUT cycles.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): all outputs 0; synchronizer flops 0; cnt 0; state IDLE.
- Input path: 2-flop synchronizer gives s. s_d is s delayed one cycle. rise = s & ~s_d; fall = ~s & s_d.
- Latency: a raw edge first sampled at clk edge N is detected as rise/fall at edge N+2. Outputs are registered at that edge.
- States: IDLE, ARM, HIGH, LOW.
- IDLE: cnt=0, busy=0. en=1 → ARM with cnt=0.
- ARM: cnt increments (saturating) each cycle. On rise → HIGH, cnt=1, no meas_valid.
- HIGH: cnt increments each non-rise cycle.
  - On fall: hi_lat ← cnt, cnt ← cnt+1, → LOW.
- LOW: cnt increments each non-rise cycle.
  - On rise: period_cnt ← cnt, high_cnt ← hi_lat, meas_valid=1, stuck_high=stuck_low=0, cnt ← 1, → HIGH.
- First meas_valid follows the second detected rise after enable.
- Example: line high 3 cycles, low 7 cycles → high_cnt=3, period_cnt=10.
- Timeout: when cnt reaches TIMEOUT with no edge:
  - in HIGH → stuck_high=1, state → ARM;
  - in LOW → stuck_low=1, state → ARM;
  - in ARM → stuck_high=s, stuck_low=~s.
  - cnt holds at TIMEOUT while stuck. Flags are sticky until the next meas_valid, en=0, or reset.
- Simultaneous events: an edge in the same cycle as cnt reaching TIMEOUT is treated as an edge; no flag is raised.
- Counter: saturates at 2^CNT_W−1 and never wraps.
- en deasserted in any state: → IDLE next edge; meas_valid=0; stuck flags cleared; cnt=0; high_cnt/period_cnt hold their last values.
- Re-enable: restarts from ARM. A measurement in progress is discarded.
- meas_valid is never asserted for two consecutive cycles. Minimum reported period is 2.
- Reset mid-operation: immediate return to reset values; no partial measurement is reported.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined: a glitch filter sits between the synchronizer and edge detection.
  - The filtered signal changes only after s has held the new value for FILTER_LEN consecutive cycles.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - Detection latency increases by FILTER_LEN cycles. Measured widths are unchanged because both edges are delayed equally.
  - Filter state resets to 0.
- Undefined: the filter logic is absent and s feeds edge detection directly.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with pwm_in toggling → all outputs 0 and busy=0. After rst_n=1 and en=1 → busy=1 on the next cycle.
- Steady PWM, 3 high / 7 low, en=1 → first meas_valid after the 2nd rise with high_cnt=3, period_cnt=10. It then repeats every 10 cycles, single-cycle wide.
- Duty change mid-stream from 3/10 to 7/10 → next complete period reports high_cnt=7, period_cnt=10, with no intermediate bogus value.
- Stuck, TIMEOUT=50: hold pwm_in=1 → stuck_high=1 once cnt reaches 50 and no meas_valid. Resume 3/10 → stuck_high clears on the first new meas_valid. Repeat with pwm_in=0 to check stuck_low.
- en dropped during HIGH → IDLE, no meas_valid, outputs hold. Re-enable → first meas_valid after two further rises.
- 1-cycle high glitch inside the low phase, FILTER_LEN=3:
  - with PWM_CAPTURE_FILTER_EN → ignored, period_cnt=10 continues;
  - without it → a meas_valid reports period_cnt less than 10 and high_cnt=1.
